id_pair_packer: RTL and testbench

//  Packs the narrow ID-pair stream produced by tanimoto_top (one {ID_A,ID_B} per beat) into full-width
//  AXI-Stream words for the result DMA. Sits directly downstream of the accelerator's M_AXIS_ID_PAIR port.

---
 rtl/id_pair_packer.sv | 154 +++++++++++++++
 tb/tb_id_pair_packer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_pair_packer.sv
// id_pair_packer
// Packs a stream of narrow {ID_A,ID_B} pairs into wide AXI-Stream words for
// the result DMA. Slot 0 sits at the LSBs. A word goes out when every slot is
// filled or when the input marks the frame's last pair. A partial word is
// flushed with tkeep covering only the filled slots. A per-frame word count
// and a frame-done pulse are reported for status.
//
// Handshake semantics (both ports are strict AXI-Stream valid/ready):
//   - A beat transfers on a rising edge where tvalid && tready are both high.
//   - The output holds tdata/tkeep/tlast stable while tvalid && !tready.
//   - The input tready is !M_tvalid || M_tready. It depends only on the
//     output register and downstream ready, and never on S_tvalid/S_tlast.
//     The output register can therefore be refilled in the same cycle that
//     it drains, which sustains one pair per cycle with no skid buffer.
//   - S_tlast is ignored when S_tvalid is low. A frame with no pairs
//     produces no output word.

module id_pair_packer #(
  parameter int VEC_ID_WIDTH   = 8,
  parameter int PAIR_WIDTH     = 2 * VEC_ID_WIDTH,
  parameter int OUT_WIDTH      = 128,
  parameter int PAIRS_PER_WORD = OUT_WIDTH / PAIR_WIDTH,
  parameter int SLOT_WIDTH     = (PAIRS_PER_WORD > 1) ? $clog2(PAIRS_PER_WORD) : 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rstn,
  // narrow ID-pair input
  input  logic [PAIR_WIDTH-1:0]   S_AXIS_ID_PAIR_tdata,
  input  logic                    S_AXIS_ID_PAIR_tvalid,
  input  logic                    S_AXIS_ID_PAIR_tlast,
  output logic                    S_AXIS_ID_PAIR_tready,
  // packed word output
  output logic [OUT_WIDTH-1:0]    M_AXIS_PACKED_tdata,
  output logic [OUT_WIDTH/8-1:0]  M_AXIS_PACKED_tkeep,
  output logic                    M_AXIS_PACKED_tvalid,
  output logic                    M_AXIS_PACKED_tlast,
  input  logic                    M_AXIS_PACKED_tready,
  // status
  output logic [31:0]             o_Word_Count,
  output logic                    o_Frame_Done
);

  localparam int KEEP_WIDTH     = OUT_WIDTH / 8;
  localparam int BYTES_PER_PAIR = PAIR_WIDTH / 8;
  localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(PAIRS_PER_WORD - 1);

  // accumulator for the word being filled
  logic [OUT_WIDTH-1:0]  acc_q;
  logic [SLOT_WIDTH-1:0] slot_q;

  // registered output word
  logic [OUT_WIDTH-1:0]  out_data_q;
  logic [KEEP_WIDTH-1:0] out_keep_q;
  logic                  out_last_q;
  logic                  out_valid_q;

  // status registers
  logic [31:0]           word_count_q;
  logic                  frame_done_q;

  // handshake and word-completion qualifiers
  logic                  in_ready;
  logic                  in_hs;
  logic                  out_hs;
  logic                  word_done;
  logic                  slot_full;

  // accumulator with the incoming pair merged in, plus tkeep for the current slot
  logic [OUT_WIDTH-1:0]  acc_merged;
  logic [KEEP_WIDTH-1:0] keep_for_slot;

  assign in_ready  = !out_valid_q || M_AXIS_PACKED_tready;
  assign in_hs     = S_AXIS_ID_PAIR_tvalid && in_ready;
  assign out_hs    = out_valid_q && M_AXIS_PACKED_tready;
  assign slot_full = (slot_q == LAST_SLOT);
  assign word_done = in_hs && (slot_full || S_AXIS_ID_PAIR_tlast);

  // Merge the incoming pair into its slot and build the byte enables for slots 0..slot_q.
  // Slots above slot_q are still zero because the accumulator clears after every word.
  always_comb begin
    acc_merged    = acc_q;
    keep_for_slot = '0;
    for (int i = 0; i < PAIRS_PER_WORD; i++) begin
      if (slot_q == SLOT_WIDTH'(i)) begin
        acc_merged[i*PAIR_WIDTH +: PAIR_WIDTH] = S_AXIS_ID_PAIR_tdata;
      end
      if (SLOT_WIDTH'(i) <= slot_q) begin
        keep_for_slot[i*BYTES_PER_PAIR +: BYTES_PER_PAIR] = '1;
      end
    end
  end

  // Accumulator and slot pointer: fill slot by slot, clear when a word is handed to the output.
  always_ff @(posedge ap_clk) begin
    if (!ap_rstn) begin
      acc_q  <= '0;
      slot_q <= '0;
    end else if (in_hs) begin
      if (word_done) begin
        acc_q  <= '0;
        slot_q <= '0;
      end else begin
        acc_q  <= acc_merged;
        slot_q <= slot_q + SLOT_WIDTH'(1);
      end
    end
  end

  // Output register: load a completed word, hold it while stalled, drop valid once it drains.
  always_ff @(posedge ap_clk) begin
    if (!ap_rstn) begin
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (word_done) begin
      out_data_q  <= acc_merged;
      out_keep_q  <= keep_for_slot;
      out_last_q  <= S_AXIS_ID_PAIR_tlast;
      out_valid_q <= 1'b1;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  // Per-frame word count: bump on every load and restart after the frame's last word drains.
  always_ff @(posedge ap_clk) begin
    if (!ap_rstn) begin
      word_count_q <= '0;
    end else if (out_hs && out_last_q) begin
      word_count_q <= word_done ? 32'd1 : 32'd0;
    end else if (word_done) begin
      word_count_q <= word_count_q + 32'd1;
    end
  end

  // Frame-done pulse: high for the single cycle after the last word of a frame is accepted.
  always_ff @(posedge ap_clk) begin
    if (!ap_rstn) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= out_hs && out_last_q;
    end
  end

  assign S_AXIS_ID_PAIR_tready = in_ready;
  assign M_AXIS_PACKED_tdata   = out_data_q;
  assign M_AXIS_PACKED_tkeep   = out_keep_q;
  assign M_AXIS_PACKED_tlast   = out_last_q;
  assign M_AXIS_PACKED_tvalid  = out_valid_q;
  assign o_Word_Count          = word_count_q;
  assign o_Frame_Done          = frame_done_q;

endmodule

// File: tb/tb_id_pair_packer.sv
// Testbench for id_pair_packer.
// The driver issues pairs. On each accepted pair, a frame-level reference
// model rebuilds the expected words arithmetically and pushes them into the
// scoreboard queues. A negedge monitor compares every word the DUT presents,
// along with output stability, word count and frame-done.

module tb_id_pair_packer;

  localparam int PW  = 16;
  localparam int OW  = 128;
  localparam int PPW = OW / PW;
  localparam int KW  = OW / 8;

  // clock / reset
  logic ap_clk = 1'b0;
  logic ap_rstn = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // DUT signals
  logic [PW-1:0] s_tdata  = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast  = 1'b0;
  logic          s_tready;
  logic [OW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic [31:0]   word_count;
  logic          frame_done;

  id_pair_packer dut (
    .ap_clk                (ap_clk),
    .ap_rstn               (ap_rstn),
    .S_AXIS_ID_PAIR_tdata  (s_tdata),
    .S_AXIS_ID_PAIR_tvalid (s_tvalid),
    .S_AXIS_ID_PAIR_tlast  (s_tlast),
    .S_AXIS_ID_PAIR_tready (s_tready),
    .M_AXIS_PACKED_tdata   (m_tdata),
    .M_AXIS_PACKED_tkeep   (m_tkeep),
    .M_AXIS_PACKED_tvalid  (m_tvalid),
    .M_AXIS_PACKED_tlast   (m_tlast),
    .M_AXIS_PACKED_tready  (m_tready),
    .o_Word_Count          (word_count),
    .o_Frame_Done          (frame_done)
  );

  // scoreboard state
  logic [OW-1:0] exp_q[$];
  logic [KW-1:0] exp_keep_q[$];
  logic          exp_last_q[$];
  int            exp_idx_q[$];
  logic [PW-1:0] word_pairs[$];
  int            words_in_frame = 0;

  int checks = 0;
  int fails  = 0;

  // monitor state
  bit            mon_en      = 1'b0;
  bit            rnd_ready   = 1'b0;
  bit            expect_load = 1'b0;
  bit            exp_fd      = 1'b0;
  bit            stalled     = 1'b0;
  int            last_idx    = 0;
  logic [OW-1:0] held_data;
  logic [KW-1:0] held_keep;
  logic          held_last;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: collect pairs of the current word and emit the expected word on fill or tlast
  task automatic model_accept(input logic [PW-1:0] d, input logic l);
    logic [OW-1:0] w;
    int n;
    word_pairs.push_back(d);
    if (l || word_pairs.size() == PPW) begin
      w = '0;
      n = word_pairs.size();
      for (int i = 0; i < n; i++) w = w | (OW'(word_pairs[i]) << (PW * i));
      exp_q.push_back(w);
      exp_keep_q.push_back(KW'((32'd1 << (n * PW / 8)) - 32'd1));
      exp_last_q.push_back(l);
      words_in_frame++;
      exp_idx_q.push_back(words_in_frame);
      if (l) words_in_frame = 0;
      word_pairs.delete();
      expect_load = 1'b1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_keep_q.delete();
    exp_last_q.delete();
    exp_idx_q.delete();
    word_pairs.delete();
    words_in_frame = 0;
    expect_load = 1'b0;
    exp_fd = 1'b0;
    stalled = 1'b0;
    last_idx = 0;
  endtask

  // downstream ready: always high, or random when backpressure is enabled
  always @(posedge ap_clk) begin
    #1;
    m_tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // monitor: one evaluation per cycle, away from the active edge
  always @(negedge ap_clk) begin
    if (mon_en && ap_rstn) begin
      check("frame_done", {127'd0, frame_done}, {127'd0, exp_fd});
      exp_fd = 1'b0;
      if (expect_load) begin
        check("load_latency", {127'd0, m_tvalid}, 128'd1);
        expect_load = 1'b0;
      end
      if (stalled) begin
        check("stall_valid", {127'd0, m_tvalid}, 128'd1);
        check("stall_data", m_tdata, held_data);
        check("stall_keep", {{(OW-KW){1'b0}}, m_tkeep}, {{(OW-KW){1'b0}}, held_keep});
        check("stall_last", {127'd0, m_tlast}, {127'd0, held_last});
      end
      stalled = 1'b0;
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 128'd1, 128'd0);
        end else begin
          check("word_data", m_tdata, exp_q[0]);
          check("word_keep", {{(OW-KW){1'b0}}, m_tkeep}, {{(OW-KW){1'b0}}, exp_keep_q[0]});
          check("word_last", {127'd0, m_tlast}, {127'd0, exp_last_q[0]});
          check("word_count", {96'd0, word_count}, OW'(exp_idx_q[0]));
          if (m_tready) begin
            exp_fd   = exp_last_q[0];
            last_idx = exp_last_q[0] ? 0 : exp_idx_q[0];
            void'(exp_q.pop_front());
            void'(exp_keep_q.pop_front());
            void'(exp_last_q.pop_front());
            void'(exp_idx_q.pop_front());
          end else begin
            stalled   = 1'b1;
            held_data = m_tdata;
            held_keep = m_tkeep;
            held_last = m_tlast;
          end
        end
      end else begin
        check("word_count_idle", {96'd0, word_count}, OW'(last_idx));
      end
    end
  end

  // driver tasks: all start and end at posedge + 1
  task automatic send_pair(input logic [PW-1:0] d, input logic l);
    int guard = 0;
    bit acc = 1'b0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = l;
    while (!acc && guard < 1000) begin
      @(negedge ap_clk);
      acc = s_tready;
      @(posedge ap_clk);
      guard++;
    end
    if (acc) model_accept(d, l);
    else check("tready_timeout", 128'd0, 128'd1);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic gap_cycle();
    s_tvalid = 1'b0;
    s_tlast  = ($urandom_range(0, 1) == 1);
    s_tdata  = PW'($urandom);
    @(posedge ap_clk);
    #1;
    s_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || m_tvalid) && guard < 500) begin
      @(posedge ap_clk);
      guard++;
    end
    check("drain_timeout", {127'd0, guard < 500}, 128'd1);
    idle(2);
  endtask

  task automatic send_frame(input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) gap_cycle();
      send_pair(PW'($urandom), i == len - 1);
    end
  endtask

  // main sequence
  initial begin
    // reset held for 3 cycles with tvalid high
    ap_rstn  = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 16'h1234;
    s_tlast  = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_tvalid", {127'd0, m_tvalid}, 128'd0);
    check("rst_tlast", {127'd0, m_tlast}, 128'd0);
    check("rst_tdata", m_tdata, 128'd0);
    check("rst_tkeep", {{(OW-KW){1'b0}}, m_tkeep}, 128'd0);
    check("rst_word_count", {96'd0, word_count}, 128'd0);
    check("rst_frame_done", {127'd0, frame_done}, 128'd0);
    check("rst_s_tready", {127'd0, s_tready}, 128'd1);
    @(posedge ap_clk);
    #1;
    ap_rstn  = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    model_reset();
    mon_en = 1'b1;
    idle(4);
    check("post_rst_no_word", {127'd0, m_tvalid}, 128'd0);

    // full word 0x0001..0x0008
    for (int i = 1; i <= 8; i++) send_pair(PW'(i), i == 8);
    drain();

    // partial flush of three pairs
    send_pair(16'hAAAA, 1'b0);
    send_pair(16'hBBBB, 1'b0);
    send_pair(16'hCCCC, 1'b1);
    drain();

    // 20 pairs under random backpressure
    rnd_ready = 1'b1;
    send_frame(20, 1'b0);
    drain();
    rnd_ready = 1'b0;
    idle(2);

    // back-to-back frames: 8 pairs then 1 pair
    for (int i = 0; i < 8; i++) send_pair(PW'($urandom), i == 7);
    send_pair(16'h5A5A, 1'b1);
    drain();

    // reset mid-frame: 5 pairs dropped, then a 2-pair frame
    for (int i = 0; i < 5; i++) send_pair(PW'($urandom), 1'b0);
    mon_en  = 1'b0;
    ap_rstn = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rstn = 1'b1;
    model_reset();
    mon_en = 1'b1;
    send_pair(16'h1111, 1'b0);
    send_pair(16'h2222, 1'b1);
    drain();

    // random frames with gaps and stray tlast on idle cycles
    for (int f = 0; f < 8; f++) begin
      rnd_ready = f[0];
      send_frame($urandom_range(1, 20), 1'b1);
    end
    rnd_ready = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
